// File: rtl/tt_um_cell_test_sequencer_pkg.sv
// Shared definitions for the cell test sequencer: FSM encoding, vector count
// and pin positions on the uio bus.
package tt_um_cell_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_PULSE  = 3'd4,
        ST_DONE   = 3'd5
    } tcs_state_t;

    localparam int NUM_VECTORS = 4;

    // Outputs toward the cell block
    localparam int UIO_A_BIT    = 0;
    localparam int UIO_B_BIT    = 1;
    localparam int UIO_DCLK_BIT = 2;

    // Responses coming back from the cell block
    localparam int UIO_AND_BIT  = 4;
    localparam int UIO_OR_BIT   = 5;
    localparam int UIO_XOR_BIT  = 6;
    localparam int UIO_Q_BIT    = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'h07;

endpackage

// File: rtl/tt_um_cell_test_sequencer_expect_model.sv
// Combinational reference for the cell block: expected {q, xor, or, and}
// plus a care mask that hides the flop output while its state is unknown.
module tcs_expect_model (
    input  logic       a,
    input  logic       b,
    input  logic       q_model,
    input  logic       mask_q,
    output logic [3:0] exp_bits,
    output logic [3:0] care
);

    // Expected response and which of its bits are meaningful this sample
    assign exp_bits = {q_model, a ^ b, a | b, a & b};
    assign care     = {~mask_q, 3'b111};

endmodule

// File: rtl/tt_um_cell_test_sequencer.sv
// Self-test controller for an off-chip AND/OR/XOR/DFF cell block. Walks the
// four {b,a} vectors NUM_PASSES times, pulses the block's clock once per
// vector, checks the responses and reports a saturating mismatch count.
module tt_um_cell_test_sequencer
    import tt_um_cell_test_sequencer_pkg::*;
#(
    parameter int NUM_PASSES = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LAST_PASS = 8'(NUM_PASSES - 1);
    localparam logic [1:0]       LAST_IDX  = 2'(NUM_VECTORS - 1);

    tcs_state_t        state;
    logic [1:0]        idx;
    logic [7:0]        pass_cnt;
    logic [3:0]        settle_len;
    logic [3:0]        settle_cnt;
    logic              q_model;
    logic              start_prev;
    logic [CNT_W-1:0]  mis_cnt;
    logic              last_mis;
    logic              busy_flag;
    logic              done_flag;
    logic              pass_flag;
    logic [1:0]        vec_ab;
    logic              dut_clk;

    logic              start_edge;
    logic              abort;
    logic              busy_state;
    logic              first_vec;
    logic [3:0]        resp;
    logic [3:0]        exp_bits;
    logic [3:0]        care;
    logic              mismatch;
    logic              unused_bits;

    assign start_edge = ui_in[0] & ~start_prev;
    assign abort      = ui_in[1];
    assign busy_state = (state == ST_DRIVE) || (state == ST_SETTLE) ||
                        (state == ST_SAMPLE) || (state == ST_PULSE);
    assign first_vec  = (idx == 2'd0) && (pass_cnt == 8'd0);
    assign resp       = {uio_in[UIO_Q_BIT], uio_in[UIO_XOR_BIT],
                         uio_in[UIO_OR_BIT], uio_in[UIO_AND_BIT]};
    assign mismatch   = |((resp ^ exp_bits) & care);
    assign unused_bits = &{1'b0, uio_in[3:0], ui_in[3:2]};

    tcs_expect_model u_expect (
        .a        (vec_ab[0]),
        .b        (vec_ab[1]),
        .q_model  (q_model),
        .mask_q   (first_vec),
        .exp_bits (exp_bits),
        .care     (care)
    );

    // Sequencer FSM with its counters, reference flop and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            pass_cnt   <= 8'd0;
            settle_len <= 4'd0;
            settle_cnt <= 4'd0;
            q_model    <= 1'b0;
            start_prev <= 1'b0;
            mis_cnt    <= '0;
            last_mis   <= 1'b0;
            busy_flag  <= 1'b0;
            done_flag  <= 1'b0;
            pass_flag  <= 1'b0;
            vec_ab     <= 2'd0;
            dut_clk    <= 1'b0;
        end else if (ena) begin
            start_prev <= ui_in[0];
            if (busy_state && abort) begin
                state     <= ST_IDLE;
                idx       <= 2'd0;
                pass_cnt  <= 8'd0;
                vec_ab    <= 2'd0;
                dut_clk   <= 1'b0;
                busy_flag <= 1'b0;
                done_flag <= 1'b0;
                pass_flag <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_edge && !abort) begin
                            state      <= ST_DRIVE;
                            idx        <= 2'd0;
                            pass_cnt   <= 8'd0;
                            settle_len <= ui_in[7:4];
                            mis_cnt    <= '0;
                            busy_flag  <= 1'b1;
                            done_flag  <= 1'b0;
                            pass_flag  <= 1'b0;
                            vec_ab     <= 2'd0;
                            dut_clk    <= 1'b0;
                        end
                    end
                    ST_DRIVE: begin
                        if (settle_len == 4'd0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= settle_len - 4'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 4'd0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        last_mis <= mismatch;
                        if (mismatch && (mis_cnt != CNT_MAX)) begin
                            mis_cnt <= mis_cnt + CNT_ONE;
                        end
                        state   <= ST_PULSE;
                        dut_clk <= 1'b1;
                    end
                    ST_PULSE: begin
                        dut_clk <= 1'b0;
                        q_model <= vec_ab[0];
                        idx     <= idx + 2'd1;
                        if ((idx == LAST_IDX) && (pass_cnt == LAST_PASS)) begin
                            state     <= ST_DONE;
                            vec_ab    <= 2'd0;
                            busy_flag <= 1'b0;
                            done_flag <= 1'b1;
                            pass_flag <= (mis_cnt == '0);
                        end else begin
                            state  <= ST_DRIVE;
                            vec_ab <= idx + 2'd1;
                            if (idx == LAST_IDX) begin
                                pass_cnt <= pass_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Place the stimulus and cell clock on their uio pins
    always_comb begin
        uio_out               = 8'h00;
        uio_out[UIO_A_BIT]    = vec_ab[0];
        uio_out[UIO_B_BIT]    = vec_ab[1];
        uio_out[UIO_DCLK_BIT] = dut_clk;
    end

    assign uio_oe = UIO_OE_MASK;
    assign uo_out = {last_mis, pass_flag, done_flag, busy_flag, 4'(mis_cnt)};

endmodule
